// File: rtl/ram_responder_if.sv
// Request/response bundle between a requester (master) and ram_responder (slave).
// Handshake is four-phase: the master holds operation != 0 until done rises,
// then returns operation to 0; done falls one edge later and the slave is idle.
interface ram_responder_if;
    logic [1:0]  operation;
    logic [3:0]  address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        done;
    logic        busy;
    logic        parity_err;

    modport master (
        output operation, address, data_in,
        input  data_out, done, busy, parity_err
    );

    modport slave (
        input  operation, address, data_in,
        output data_out, done, busy, parity_err
    );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: 16 x 16-bit register RAM driven by a four-phase request
// handshake (IDLE/GET/SET/RESET). Optional per-word even parity is enabled by
// defining RAM_RESPONDER_PARITY_EN; without it parity_err is tied to 0.
module ram_responder #(
    parameter int          GET_LAT  = 1,
    parameter logic [15:0] CLR_DATA = 16'h0000
) (
    input  logic           clk,
    input  logic           reset_n,
    ram_responder_if.slave bus,
    output logic [2:0]     dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GET  = 3'd1,
        S_SET  = 3'd2,
        S_CLR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] LAT_LOAD = 2'(GET_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  lat_q, lat_d;
    logic [3:0]  sweep_q, sweep_d;
    logic [15:0] dout_q, dout_d;
    logic        done_q, done_d;
    logic        perr_q, perr_d;
    logic [15:0] mem_q [16];

    logic        mem_we;
    logic [3:0]  mem_wa;
    logic [15:0] mem_wd;
    logic        perr_calc;

`ifdef RAM_RESPONDER_PARITY_EN
    logic mem_par_q [16];

    // Stored parity versus parity recomputed from the stored word.
    always_comb perr_calc = mem_par_q[addr_q] ^ (^mem_q[addr_q]);

    // Parity bit tracks every write into the array.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mem_par_q[i] <= 1'b0;
        end else if (mem_we) begin
            mem_par_q[mem_wa] <= ^mem_wd;
        end
    end
`else
    assign perr_calc = 1'b0;
`endif

    // Next-state and datapath decisions; every output defaults to hold.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lat_d   = lat_q;
        sweep_d = sweep_q;
        dout_d  = dout_q;
        done_d  = done_q;
        perr_d  = perr_q;
        mem_we  = 1'b0;
        mem_wa  = addr_q;
        mem_wd  = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.operation != 2'd0) begin
                    addr_d  = bus.address;
                    wdata_d = bus.data_in;
                    lat_d   = LAT_LOAD;
                    sweep_d = 4'd0;
                    case (bus.operation)
                        2'd1:    state_d = S_GET;
                        2'd2:    state_d = S_SET;
                        default: state_d = S_CLR;
                    endcase
                end
            end
            S_GET: begin
                if (lat_q == 2'd0) begin
                    dout_d  = mem_q[addr_q];
                    done_d  = 1'b1;
                    perr_d  = perr_calc;
                    state_d = S_DONE;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_SET: begin
                mem_we  = 1'b1;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_CLR: begin
                // One word per edge; the counter parks at 15 once the sweep ends.
                mem_we = 1'b1;
                mem_wa = sweep_q;
                mem_wd = CLR_DATA;
                if (sweep_q == 4'd15) begin
                    done_d  = 1'b1;
                    dout_d  = CLR_DATA;
                    state_d = S_DONE;
                end else begin
                    sweep_d = sweep_q + 4'd1;
                end
            end
            S_DONE: begin
                if (bus.operation == 2'd0) begin
                    done_d  = 1'b0;
                    perr_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            lat_q   <= '0;
            sweep_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lat_q   <= lat_d;
            sweep_q <= sweep_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
        end
    end

    // Storage array; reset clears every word, including a half-done sweep.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.parity_err = perr_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;
  localparam int          GET_LAT  = 1;
  localparam logic [15:0] CLR_DATA = 16'h0000;
  localparam logic [1:0]  OP_IDLE  = 2'd0;
  localparam logic [1:0]  OP_GET   = 2'd1;
  localparam logic [1:0]  OP_SET   = 2'd2;
  localparam logic [1:0]  OP_RESET = 2'd3;

  logic       clk;
  logic       reset_n;
  logic [2:0] dbg_state;
  ram_responder_if bus ();

  ram_responder #(.GET_LAT(GET_LAT), .CLR_DATA(CLR_DATA)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: plain array plus the last value seen on data_out
  logic [15:0] mem_m [16];
  logic [15:0] dout_m;
  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Full four-phase transaction. Called #1 after a rising edge while idle.
  task automatic do_op(input logic [1:0] op, input logic [3:0] addr, input logic [15:0] data,
                       input int hold, input logic exp_perr);
    int lat_exp;
    int cycles;
    bus.operation = op;
    bus.address   = addr;
    bus.data_in   = data;
    // edges counted include the accept edge
    lat_exp = (op == OP_GET) ? GET_LAT + 1 : (op == OP_SET) ? 2 : 17;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1) begin
        // inputs other than operation must be ignored once accepted
        bus.address = 4'($urandom);
        bus.data_in = 16'($urandom);
      end
    end while (!bus.done && cycles < 40);
    check_eq("done_rise", bus.done, 1'b1);
    check_eq("latency", cycles, lat_exp);
    case (op)
      OP_GET: dout_m = mem_m[addr];
      OP_SET: mem_m[addr] = data;
      default: begin
        for (int i = 0; i < 16; i++) mem_m[i] = CLR_DATA;
        dout_m = CLR_DATA;
      end
    endcase
    check_eq("data_out", bus.data_out, dout_m);
    check_eq("busy_done", bus.busy, 1'b1);
    check_eq("parity_err", bus.parity_err, exp_perr);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq("hold_done", bus.done, 1'b1);
      check_eq("hold_data", bus.data_out, dout_m);
    end
    bus.operation = OP_IDLE;
    @(posedge clk); #1;
    check_eq("done_fall", bus.done, 1'b0);
    check_eq("busy_idle", bus.busy, 1'b0);
    check_eq("perr_clear", bus.parity_err, 1'b0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [15:0] d;
    int          r;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) mem_m[i] = 16'h0000;
    dout_m = 16'h0000;
    reset_n       = 1'b0;
    bus.operation = OP_IDLE;
    bus.address   = 4'd0;
    bus.data_in   = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_dout", bus.data_out, 16'h0000);
    check_eq("rst_perr", bus.parity_err, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // SET then GET at address 5; the first accept falls on the first edge
    do_op(OP_SET, 4'd5, 16'h1234, 0, 1'b0);
    do_op(OP_GET, 4'd5, 16'h0000, 0, 1'b0);
    // request held for 10 cycles after done
    do_op(OP_GET, 4'd5, 16'h0000, 10, 1'b0);

    // late input changes at half a cycle after the accept edge
    bus.operation = OP_SET;
    bus.address   = 4'd3;
    bus.data_in   = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    bus.address = 4'd9;
    bus.data_in = 16'h5555;
    @(posedge clk); #1;
    check_eq("late_done", bus.done, 1'b1);
    mem_m[3] = 16'hAAAA;
    bus.operation = OP_IDLE;
    @(posedge clk); #1;
    do_op(OP_GET, 4'd3, 16'h0000, 0, 1'b0);
    do_op(OP_GET, 4'd9, 16'h0000, 0, 1'b0);

    // fill with all ones, clear, read back edges and middle
    for (int a = 0; a < 16; a++) do_op(OP_SET, 4'(a), 16'hFFFF, 0, 1'b0);
    do_op(OP_RESET, 4'd0, 16'h0000, 1, 1'b0);
    do_op(OP_GET, 4'd0, 16'h0000, 0, 1'b0);
    do_op(OP_GET, 4'd7, 16'h0000, 0, 1'b0);
    do_op(OP_GET, 4'd15, 16'h0000, 0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      op = (r == 0) ? OP_RESET : (r < 5) ? OP_SET : OP_GET;
      do_op(op, 4'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 3), 1'b0);
    end

    // reset in the middle of a clear sweep
    for (int a = 0; a < 16; a++) do_op(OP_SET, 4'(a), 16'($urandom_range(1, 16'hFFFF)), 0, 1'b0);
    bus.operation = OP_RESET;
    repeat (7) @(posedge clk);
    #1;
    check_eq("sweep_busy", bus.busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check_eq("abort_busy", bus.busy, 1'b0);
    check_eq("abort_done", bus.done, 1'b0);
    check_eq("abort_dout", bus.data_out, 16'h0000);
    for (int i = 0; i < 16; i++) mem_m[i] = 16'h0000;
    dout_m = 16'h0000;
    bus.operation = OP_IDLE;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 16; a += 3) do_op(OP_GET, 4'(a), 16'h0000, 0, 1'b0);
    do_op(OP_GET, 4'd15, 16'h0000, 0, 1'b0);

`ifdef RAM_RESPONDER_PARITY_EN
    // corrupt one stored bit behind the parity bit's back
    d = 16'($urandom);
    do_op(OP_SET, 4'd2, d, 0, 1'b0);
    do_op(OP_SET, 4'd4, 16'($urandom), 0, 1'b0);
    mem_m[2] = mem_m[2] ^ 16'h0001;
    dut.mem_q[2] = mem_m[2];
    do_op(OP_GET, 4'd2, 16'h0000, 2, 1'b1);
    do_op(OP_GET, 4'd4, 16'h0000, 0, 1'b0);
`else
    d = 16'h0000;
    check_eq("perr_const", bus.parity_err, d[0]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter GET_LAT, default 1, meaning clock edges from GET acceptance to done; legal range 1..4.
REQ-002 Parameter CLR_DATA, default 16'h0000, meaning the word value written by a RESET operation.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 operation  input  2  request code: 0 IDLE, 1 GET, 2 SET, 3 RESET.
REQ-006 address  input  4  word address, 0..15.
REQ-007 data_in  input  16  write data for SET.
REQ-008 data_out  output  16  read data, registered.
REQ-009 done  output  1  completion flag, registered.
REQ-010 busy  output  1  high in every state except S_IDLE.
REQ-011 parity_err  output  1  read parity mismatch flag, registered.

Function
REQ-012 Storage SHALL be 16 words x 16 bits, registers only.
REQ-013 FSM states SHALL be S_IDLE, S_GET, S_SET, S_CLR and S_DONE.
REQ-014 In S_IDLE, at an edge with operation != 0 (accept edge A), the block SHALL latch operation, address and data_in and move to S_GET, S_SET or S_CLR.
REQ-015 Input changes after accept edge A SHALL be ignored until the block returns to S_IDLE.
REQ-016 GET: data_out SHALL equal mem[address] and done SHALL be 1 after edge A+GET_LAT, via a down-counter in S_GET.
REQ-017 SET: mem[address] SHALL be written with data_in at edge A+1, and done SHALL be 1 after that same edge.
REQ-018 RESET: a 4-bit sweep counter SHALL write CLR_DATA to word k at edge A+1+k for k = 0..15.
REQ-019 RESET: done SHALL be 1 and data_out SHALL be CLR_DATA after edge A+16.
REQ-020 S_DONE SHALL hold done=1 and data_out stable while operation != 0 (four-phase handshake).
REQ-021 At the first edge in S_DONE with operation == 0, the block SHALL clear done and go to S_IDLE.
REQ-022 A new request SHALL be accepted no earlier than the edge after done falls.
REQ-023 A request already present when entering S_IDLE SHALL be accepted on the next edge, with no extra idle cycle.
REQ-024 Outside GET and RESET completion, data_out SHALL hold its last value; SET SHALL not change data_out.
REQ-025 Address wrap: the sweep counter SHALL stop at 15 and SHALL not write again.

Reset
REQ-026 While reset_n == 0: state S_IDLE, all 16 words 0, data_out 0, done 0, busy 0, parity_err 0, all counters 0.
REQ-027 Assertion of reset_n mid-operation SHALL abort the operation immediately; a partially completed RESET sweep SHALL leave all words 0.
REQ-028 After reset_n deasserts, the first acceptance SHALL be possible on the first clk edge.

Configuration
REQ-029 Macro RAM_RESPONDER_PARITY_EN SHALL control a per-word parity feature.
REQ-030 With RAM_RESPONDER_PARITY_EN defined, each word SHALL carry a 17th even-parity bit computed on SET and RESET.
REQ-031 With RAM_RESPONDER_PARITY_EN defined, on GET completion parity_err SHALL equal the stored parity XOR the recomputed parity of the stored data.
REQ-032 With RAM_RESPONDER_PARITY_EN defined, parity_err SHALL be held through S_DONE and cleared on leaving S_DONE.
REQ-033 Without RAM_RESPONDER_PARITY_EN, no parity storage SHALL exist and parity_err SHALL be constant 0.

Verification
REQ-034 SET addr 5 data 16'h1234, drop to IDLE after done; then GET addr 5 -> done 1 edge after GET accept (GET_LAT=1), data_out 16'h1234.
REQ-035 Hold operation=GET 10 cycles after done -> done and data_out stable for all 10; done falls 1 edge after operation=0.
REQ-036 Fill all 16 words with 16'hFFFF, RESET -> done after exactly 16 edges; GETs of addresses 0, 7 and 15 return 16'h0000.
REQ-037 Accept SET addr 3 data 16'hAAAA, change address to 9 and data_in to 16'h5555 at edge A+0.5 -> word 3 = 16'hAAAA, word 9 unchanged.
REQ-038 Pull reset_n low at sweep step 6 of RESET -> busy 0 and done 0 immediately; all words read 0 after release.
REQ-039 With RAM_RESPONDER_PARITY_EN, force a stored bit flip on word 2 and GET addr 2 -> parity_err 1 with done; a clean word gives parity_err 0.
